// File: rtl/rstgen_seq.sv
// Reset sequencer: synchronises PLL lock, filters it, stretches reset and releases
// the reset domains one by one in ascending order with a fixed stagger.
module rstgen_seq #(
  parameter int NUM_DOMAINS    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int USE_LOCK       = 1
) (
  input  logic                   IO_CLK,
  input  logic                   IO_RST_N,
  input  logic                   locked_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   ready_o,
  output logic                   lock_lost_o
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);
  localparam int STAG_W = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;

  localparam logic [FILT_W-1:0]      FILT_DONE = FILT_W'(LOCK_FILTER);
  localparam logic [FILT_W-1:0]      FILT_ONE  = FILT_W'(1'b1);
  localparam logic [STR_W-1:0]       STR_LAST  = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [STR_W-1:0]       STR_ONE   = STR_W'(1'b1);
  localparam logic [STAG_W-1:0]      STAG_LAST = STAG_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [STAG_W-1:0]      STAG_ONE  = STAG_W'(1'b1);
  localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1'b1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] DOM_NONE  = {NUM_DOMAINS{1'b0}};
  // A single domain or a zero stagger means every domain leaves reset on one edge.
  localparam bit RELEASE_ALL = (NUM_DOMAINS == 1) || (STAGGER_CYCLES == 0);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                   state_r;
  logic [SYNC_STAGES-1:0]   sync_r;
  logic [FILT_W-1:0]        filt_cnt_r;
  logic [STR_W-1:0]         str_cnt_r;
  logic [STAG_W-1:0]        stag_cnt_r;
  logic [NUM_DOMAINS-1:0]   rst_n_r;
  logic                     ready_r;
  logic                     lock_lost_r;
  logic                     lock_in_s;
  logic                     lock_s;
  logic [NUM_DOMAINS-1:0]   rel_next_s;

  // Lock source: without a PLL the synchroniser is fed a constant high, so the
  // post-reset timing is identical to a PLL that is already locked.
  always_comb begin
    if (USE_LOCK != 0) begin
      lock_in_s = locked_i;
    end else begin
      lock_in_s = 1'b1;
    end
  end

  // Lock synchroniser chain.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], lock_in_s};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Next release pattern: shifting a one in from the bottom keeps the order ascending.
  always_comb begin
    rel_next_s = (rst_n_r << 1) | DOM_FIRST;
  end

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      state_r     <= WAIT_LOCK;
      filt_cnt_r  <= '0;
      str_cnt_r   <= '0;
      stag_cnt_r  <= '0;
      rst_n_r     <= DOM_NONE;
      ready_r     <= 1'b0;
      lock_lost_r <= 1'b0;
    end else if ((state_r != WAIT_LOCK) && !lock_s) begin
      // Loss of an accepted lock beats any software request in the same cycle.
      state_r     <= WAIT_LOCK;
      filt_cnt_r  <= '0;
      str_cnt_r   <= '0;
      stag_cnt_r  <= '0;
      rst_n_r     <= DOM_NONE;
      ready_r     <= 1'b0;
      lock_lost_r <= 1'b1;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          if (!lock_s) begin
            filt_cnt_r <= '0;
          end else if (filt_cnt_r == FILT_DONE) begin
            filt_cnt_r <= '0;
            state_r    <= STRETCH;
          end else begin
            filt_cnt_r <= filt_cnt_r + FILT_ONE;
          end
        end
        STRETCH: begin
          if (str_cnt_r == STR_LAST) begin
            str_cnt_r <= '0;
            if (RELEASE_ALL) begin
              rst_n_r <= DOM_ALL;
              ready_r <= 1'b1;
              state_r <= RUN;
            end else begin
              rst_n_r <= DOM_FIRST;
              state_r <= RELEASE;
            end
          end else begin
            str_cnt_r <= str_cnt_r + STR_ONE;
          end
        end
        RELEASE: begin
          if (stag_cnt_r == STAG_LAST) begin
            stag_cnt_r <= '0;
            rst_n_r    <= rel_next_s;
            if (&rel_next_s) begin
              ready_r <= 1'b1;
              state_r <= RUN;
            end else begin
              ready_r <= 1'b0;
            end
          end else begin
            stag_cnt_r <= stag_cnt_r + STAG_ONE;
          end
        end
        RUN: begin
          if (sw_rst_req_i) begin
            state_r    <= STRETCH;
            str_cnt_r  <= '0;
            stag_cnt_r <= '0;
            rst_n_r    <= DOM_NONE;
            ready_r    <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= WAIT_LOCK;
          filt_cnt_r <= '0;
          str_cnt_r  <= '0;
          stag_cnt_r <= '0;
          rst_n_r    <= DOM_NONE;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o     = rst_n_r;
  assign ready_o     = ready_r;
  assign lock_lost_o = lock_lost_r;

endmodule

// File: tb/tb_rstgen_seq.sv
// Self-checking bench for rstgen_seq: timestamp-based reference model checked every
// cycle, directed scenarios with literal release times, then randomized lock/sw/reset.
module tb_rstgen_seq;

  localparam int ND   = 3;
  localparam int SYNC = 2;
  localparam int LF   = 4;
  localparam int ST   = 16;
  localparam int SG   = 8;
  localparam int NOLOCK_REL = 22;

  logic          clk;
  logic          rst_n;
  logic          locked;
  logic          sw;
  logic [ND-1:0] rst_vec;
  logic          ready;
  logic          lost;
  logic [0:0]    rst2;
  logic          ready2;
  logic          lost2;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rstgen_seq #(
    .NUM_DOMAINS(ND), .SYNC_STAGES(SYNC), .LOCK_FILTER(LF),
    .STRETCH_CYCLES(ST), .STAGGER_CYCLES(SG), .USE_LOCK(1)
  ) dut (
    .IO_CLK(clk), .IO_RST_N(rst_n), .locked_i(locked), .sw_rst_req_i(sw),
    .rst_n_o(rst_vec), .ready_o(ready), .lock_lost_o(lost)
  );

  rstgen_seq #(
    .NUM_DOMAINS(1), .SYNC_STAGES(SYNC), .LOCK_FILTER(LF),
    .STRETCH_CYCLES(ST), .STAGGER_CYCLES(0), .USE_LOCK(0)
  ) dut_nolock (
    .IO_CLK(clk), .IO_RST_N(rst_n), .locked_i(1'b0), .sw_rst_req_i(1'b0),
    .rst_n_o(rst2), .ready_o(ready2), .lock_lost_o(lost2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: lock accepted after LF+1 consecutive synchronised-high samples;
  // domain k is released ST + k*SG edges after acceptance (or after a sw request in RUN).
  initial begin : model
    logic [SYNC-1:0] hist;
    logic [ND-1:0]   exp_rst;
    bit              acc;
    bit              lost_m;
    bit              lvl;
    bit              exp2;
    int              run_len;
    int              start;
    int              n;
    int              since;
    hist = '0; acc = 1'b0; lost_m = 1'b0; run_len = 0; start = 0; n = 0; since = 0;
    forever begin
      @(posedge clk);
      exp2 = 1'b0;
      if (!rst_n) begin
        hist = '0; acc = 1'b0; lost_m = 1'b0; run_len = 0; since = 0;
      end else begin
        lvl  = hist[SYNC-1];
        hist = {hist[SYNC-2:0], locked};
        if (!acc) begin
          if (lvl) begin
            run_len++;
            if (run_len == LF + 1) begin
              acc = 1'b1; start = n; run_len = 0;
            end
          end else begin
            run_len = 0;
          end
        end else if (!lvl) begin
          acc = 1'b0; lost_m = 1'b1; run_len = 0;
        end else if (sw && (n > start + ST + (ND - 1) * SG)) begin
          start = n;
        end
        exp2 = (since >= NOLOCK_REL);
        if (since < 1000000) since++;
      end
      for (int k = 0; k < ND; k++) exp_rst[k] = acc && (n >= start + ST + k * SG);
      n++;
      #1;
      chk("rst_n_o", int'(rst_vec), int'(exp_rst));
      chk("ready_o", int'(ready), int'(&exp_rst));
      chk("lock_lost_o", int'(lost), int'(lost_m));
      chk("nolock_rst_n_o", int'(rst2), int'(exp2));
      chk("nolock_ready_o", int'(ready2), int'(exp2));
      chk("nolock_lock_lost_o", int'(lost2), 0);
    end
  end

  // Watch ncyc edges (first edge = cycle 0) and record the first cycle each output rises.
  task automatic observe(input int ncyc, input int e0, input int e1, input int e2,
                         input bit chk2, input string tag);
    int r[ND];
    int rr;
    int r2;
    for (int k = 0; k < ND; k++) r[k] = -1;
    rr = -1;
    r2 = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) if (r[k] < 0 && rst_vec[k]) r[k] = c;
      if (rr < 0 && ready) rr = c;
      if (r2 < 0 && rst2[0] && ready2) r2 = c;
    end
    chk({tag, "_rise0"}, r[0], e0);
    chk({tag, "_rise1"}, r[1], e1);
    chk({tag, "_rise2"}, r[2], e2);
    chk({tag, "_ready"}, rr, e2);
    if (chk2) chk({tag, "_nolock_rise"}, r2, NOLOCK_REL);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    locked = 1'b0;
    sw = 1'b0;
    repeat (3) @(negedge clk);
    locked = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rst_n_o", int'(rst_vec), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_lock_lost", int'(lost), 0);

    // Lock held from reset release.
    @(negedge clk);
    rst_n = 1'b1;
    observe(50, 22, 30, 38, 1'b1, "held");
    chk("held_lock_lost", int'(lost), 0);

    // One-cycle software reset in RUN.
    @(negedge clk);
    sw = 1'b1;
    fork
      observe(40, 16, 24, 32, 1'b0, "swrst");
      begin
        @(negedge clk);
        sw = 1'b0;
      end
    join

    // Lock loss in RUN, then relock.
    @(negedge clk);
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("loss_rst_n_o", int'(rst_vec), 0);
    chk("loss_ready", int'(ready), 0);
    chk("loss_lock_lost", int'(lost), 1);
    repeat (4) @(negedge clk);
    locked = 1'b1;
    observe(50, 22, 30, 38, 1'b0, "relock");
    chk("relock_lock_lost", int'(lost), 1);

    // Asynchronous reset between edges while domains are being released.
    @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_release_rst_n_o", int'(rst_vec), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_n_o", int'(rst_vec), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_lock_lost", int'(lost), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(50, 22, 30, 38, 1'b1, "post_async");

    // One-cycle lock glitch at cycle 4 while filtering.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      observe(60, 27, 35, 43, 1'b1, "glitch");
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
      end
    join
    chk("glitch_lock_lost", int'(lost), 0);

    // Randomized lock drops, glitches, sw requests and asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      sw = ($urandom_range(0, 29) == 0);
      if (locked) locked = ($urandom_range(0, 119) != 0);
      else        locked = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rand_async_rst_n_o", int'(rst_vec), 0);
        chk("rand_async_ready", int'(ready), 0);
        chk("rand_async_lock_lost", int'(lost), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
